// File: rtl/edge_event_pkg.sv
// Shared mode encodings, parameter limits and event decode for edge_event_capture.
package edge_event_pkg;

    typedef enum logic [1:0] {
        ModeOff  = 2'b00,
        ModeRise = 2'b01,
        ModeFall = 2'b10,
        ModeBoth = 2'b11
    } mode_e;

    localparam int unsigned N_CH_MIN        = 1;
    localparam int unsigned N_CH_MAX        = 32;
    localparam int unsigned SYNC_STAGES_MIN = 2;
    localparam int unsigned SYNC_STAGES_MAX = 4;

    function automatic logic is_event(input logic [1:0] mode, input logic rise,
                                      input logic fall);
        logic w_ev;
        w_ev = 1'b0;
        case (mode_e'(mode))
            ModeRise: w_ev = rise;
            ModeFall: w_ev = fall;
            ModeBoth: w_ev = rise | fall;
            default:  w_ev = 1'b0;
        endcase
        return w_ev;
    endfunction

endpackage

// File: rtl/edge_event_capture_if.sv
// Channel bus between a controller (master) and edge_event_capture (slave).
interface edge_event_capture_if #(
    parameter int unsigned N_CH  = 8,
    parameter int unsigned DEB_W = 4
);
    logic [N_CH-1:0]   s;
    logic [2*N_CH-1:0] mode;
    logic [DEB_W-1:0]  deb_len;
    logic [N_CH-1:0]   clr;
    logic [N_CH-1:0]   irq_en;
    logic [N_CH-1:0]   level;
    logic [N_CH-1:0]   r;
    logic [N_CH-1:0]   f;
    logic [N_CH-1:0]   pending;
    logic              irq;

    modport master (
        output s, mode, deb_len, clr, irq_en,
        input  level, r, f, pending, irq
    );

    modport slave (
        input  s, mode, deb_len, clr, irq_en,
        output level, r, f, pending, irq
    );
endinterface

// File: rtl/edge_debounce_ch.sv
// One channel: synchroniser, debounce counter and registered edge pulses.
module edge_debounce_ch #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEB_W       = 4
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             i_s,
    input  logic [DEB_W-1:0] i_deb_len,
    output logic             o_level,
    output logic             o_rise,
    output logic             o_fall
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_level;
    logic [DEB_W-1:0]       r_cnt;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_sy;
    logic                   w_level_d;
    logic [DEB_W-1:0]       w_cnt_d;

    assign w_sy = r_sync[SYNC_STAGES-1];

    always_comb begin
        w_level_d = r_level;
        w_cnt_d   = r_cnt;
        if (w_sy == r_level) begin
            w_cnt_d = '0;
        end else if (r_cnt >= i_deb_len) begin
            w_level_d = w_sy;
            w_cnt_d   = '0;
        end else if (r_cnt != {DEB_W{1'b1}}) begin
            // Saturate rather than wrap so a huge D never re-arms early.
            w_cnt_d = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sync  <= '0;
            r_level <= 1'b0;
            r_cnt   <= '0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_s};
            r_level <= w_level_d;
            r_cnt   <= w_cnt_d;
            r_rise  <= w_level_d & ~r_level;
            r_fall  <= ~w_level_d & r_level;
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;
endmodule

// File: rtl/edge_event_capture.sv
// Multi-channel debounced edge detector with sticky pending bits and a shared irq.
module edge_event_capture
    import edge_event_pkg::*;
#(
    parameter int unsigned N_CH        = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEB_W       = 4
) (
    input logic                 sys_clk,
    input logic                 sys_rst_n,
    edge_event_capture_if.slave bus
);
    logic [N_CH-1:0] w_level;
    logic [N_CH-1:0] w_rise;
    logic [N_CH-1:0] w_fall;
    logic [N_CH-1:0] w_event;
    logic [N_CH-1:0] w_pending_d;
    logic [N_CH-1:0] r_pending;
    logic            r_irq;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        edge_debounce_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEB_W       (DEB_W)
        ) u_ch (
            .sys_clk   (sys_clk),
            .sys_rst_n (sys_rst_n),
            .i_s       (bus.s[g]),
            .i_deb_len (bus.deb_len),
            .o_level   (w_level[g]),
            .o_rise    (w_rise[g]),
            .o_fall    (w_fall[g])
        );
    end

    always_comb begin
        w_event = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_event[i] = is_event(bus.mode[2*i +: 2], w_rise[i], w_fall[i]);
        end
        // A new event beats a simultaneous clear so it is never lost.
        w_pending_d = (r_pending & ~bus.clr) | w_event;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_pending <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_pending <= w_pending_d;
            r_irq     <= |(r_pending & bus.irq_en);
        end
    end

    assign bus.level   = w_level;
    assign bus.r       = w_rise;
    assign bus.f       = w_fall;
    assign bus.pending = r_pending;
    assign bus.irq     = r_irq;
endmodule

// File: tb/tb_edge_event_capture.sv
// Directed bench for edge_event_capture: a per-cycle vector table plus corner sequences.
module tb_edge_event_capture;

    typedef struct packed {
        logic [7:0]  s;
        logic [15:0] mode;
        logic [3:0]  deb;
        logic [7:0]  clr;
        logic [7:0]  en;
        logic [7:0]  e_level;
        logic [7:0]  e_r;
        logic [7:0]  e_f;
        logic [7:0]  e_pend;
        logic        e_irq;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    edge_event_capture_if #(.N_CH(8), .DEB_W(4)) bus ();

    edge_event_capture #(
        .N_CH        (8),
        .SYNC_STAGES (2),
        .DEB_W       (4)
    ) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [32:0] outs();
        return {bus.level, bus.r, bus.f, bus.pending, bus.irq};
    endfunction

    vec_t vecs[11];
    int   rcnt, fcnt, rcyc, fcyc, lvl_seen;

    initial begin
        // Rising detect on ch0 with D=0, clear, then a fall that mode ignores.
        vecs[0]  = '{8'h01, 16'h0001, 4'd0, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[1]  = '{8'h01, 16'h0001, 4'd0, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[2]  = '{8'h01, 16'h0001, 4'd0, 8'h00, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 1'b0};
        vecs[3]  = '{8'h01, 16'h0001, 4'd0, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h01, 1'b0};
        vecs[4]  = '{8'h01, 16'h0001, 4'd0, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h01, 1'b1};
        vecs[5]  = '{8'h01, 16'h0001, 4'd0, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 1'b1};
        vecs[6]  = '{8'h01, 16'h0001, 4'd0, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[7]  = '{8'h00, 16'h0001, 4'd0, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[8]  = '{8'h00, 16'h0001, 4'd0, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[9]  = '{8'h00, 16'h0001, 4'd0, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 1'b0};
        vecs[10] = '{8'h00, 16'h0001, 4'd0, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};

        bus.s = '0; bus.mode = '0; bus.deb_len = '0; bus.clr = '0; bus.irq_en = '0;
        #12;
        check("reset_outputs", 64'(outs()), 64'h0);
        rst_n = 1'b1;
        repeat (3) step();
        check("idle_outputs", 64'(outs()), 64'h0);

        for (int i = 0; i < 11; i++) begin
            bus.s = vecs[i].s; bus.mode = vecs[i].mode; bus.deb_len = vecs[i].deb;
            bus.clr = vecs[i].clr; bus.irq_en = vecs[i].en;
            step();
            check($sformatf("vec%0d", i), 64'(outs()),
                  64'({vecs[i].e_level, vecs[i].e_r, vecs[i].e_f, vecs[i].e_pend,
                       vecs[i].e_irq}));
        end

        // D=3: a 3-cycle glitch on ch2 is rejected.
        bus.mode = 16'h0030; bus.deb_len = 4'd3; bus.irq_en = 8'h00;
        rcnt = 0; lvl_seen = 0;
        for (int k = 1; k <= 15; k++) begin
            bus.s = (k <= 3) ? 8'h04 : 8'h00;
            step();
            if (bus.r[2]) rcnt++;
            if (bus.level[2]) lvl_seen = 1;
        end
        check("glitch_r2", 64'(rcnt), 64'd0);
        check("glitch_level2", 64'(lvl_seen), 64'd0);
        check("glitch_pend2", 64'(bus.pending[2]), 64'd0);

        // A 4-cycle pulse passes: rise 6 edges after s rises, fall 6 after it falls.
        rcnt = 0; fcnt = 0; rcyc = 0; fcyc = 0;
        for (int k = 1; k <= 16; k++) begin
            bus.s = (k <= 4) ? 8'h04 : 8'h00;
            step();
            if (bus.r[2]) begin rcnt++; rcyc = k; end
            if (bus.f[2]) begin fcnt++; fcyc = k; end
        end
        check("pulse_r2_count", 64'(rcnt), 64'd1);
        check("pulse_f2_count", 64'(fcnt), 64'd1);
        check("pulse_r2_cycle", 64'(rcyc), 64'd6);
        check("pulse_f2_cycle", 64'(fcyc), 64'd10);
        check("pulse_pend2", 64'(bus.pending[2]), 64'd1);

        // Falling-only mode on ch1.
        bus.mode = 16'h0008; bus.deb_len = 4'd0; bus.clr = 8'hFF;
        step();
        bus.clr = 8'h00; bus.s = 8'h02; rcnt = 0;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (bus.r[1]) rcnt++;
        end
        check("fallmode_r1", 64'(rcnt), 64'd1);
        check("fallmode_pend_after_rise", 64'(bus.pending), 64'h00);
        bus.s = 8'h00;
        repeat (3) step();
        check("fallmode_f1", 64'(bus.f), 64'h02);
        step();
        check("fallmode_pend_after_fall", 64'(bus.pending), 64'h02);

        // ch3: clear coinciding with a new event keeps pending; clear alone drops it.
        bus.mode = 16'h00C0; bus.irq_en = 8'h08; bus.clr = 8'hFF;
        step();
        bus.clr = 8'h00; bus.s = 8'h08;
        repeat (3) step();
        check("ch3_r", 64'(bus.r), 64'h08);
        step();
        check("ch3_pend", 64'(bus.pending), 64'h08);
        step();
        check("ch3_irq", 64'(bus.irq), 64'd1);
        bus.s = 8'h00;
        repeat (3) step();
        check("ch3_f", 64'(bus.f), 64'h08);
        bus.clr = 8'h08;
        step();
        check("ch3_set_beats_clr", 64'(bus.pending), 64'h08);
        step();
        check("ch3_clr_alone", 64'(bus.pending), 64'h00);
        check("ch3_irq_lag", 64'(bus.irq), 64'd1);
        bus.clr = 8'h00;
        step();
        check("ch3_irq_drop", 64'(bus.irq), 64'd0);

        // All channels together, both edges.
        bus.mode = 16'hFFFF; bus.irq_en = 8'hFF; bus.s = 8'hFF;
        repeat (3) step();
        check("all_r", 64'(bus.r), 64'hFF);
        step();
        check("all_pend", 64'(bus.pending), 64'hFF);
        step();
        check("all_irq", 64'(bus.irq), 64'd1);
        bus.irq_en = 8'h00;
        step();
        check("all_irq_masked", 64'(bus.irq), 64'd0);

        // Reset mid-debounce with s[0] high.
        bus.mode = 16'h0001; bus.deb_len = 4'd3; bus.irq_en = 8'hFF; bus.s = 8'hF0;
        repeat (12) step();
        bus.clr = 8'hFF;
        step();
        bus.clr = 8'h00;
        repeat (2) step();
        bus.s = 8'hF1;
        repeat (3) step();
        check("pre_reset_level", 64'(bus.level), 64'hF0);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 64'(outs()), 64'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rcnt = 0; rcyc = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (bus.r[0]) begin rcnt++; rcyc = k; end
        end
        check("post_reset_r0_count", 64'(rcnt), 64'd1);
        check("post_reset_r0_cycle", 64'(rcyc), 64'd6);
        check("post_reset_level", 64'(bus.level), 64'hF1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
